// File: rtl/icache_np_pkg.sv
// Shared types and width helpers for the parametrised N-port L1 instruction cache.
package icache_np_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        hit;
    logic [63:0] data;
  } resp_t;

  // Never returns 0, so degenerate geometries still produce legal vector widths.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_w,
                                           input int unsigned line_bytes,
                                           input int unsigned sets);
    return addr_w - bits_for(line_bytes) - bits_for(sets);
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Single-MSHR line-refill engine: owns the memory handshake, beat counting and
// the latched line address / victim way of the refill in flight.
//
// state | meaning
// IDLE  | no refill outstanding; cache serves lookups
// REQ   | refill request presented to memory, waiting for mem_req_ready_i
// FILL  | collecting refill beats into the victim way
module icache_refill_fsm
  import icache_np_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned OFF_W  = 6,
  parameter int unsigned WAY_W  = 3,
  parameter int unsigned BEATS  = 8,
  parameter int unsigned BEAT_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_i,
  input  logic [ADDR_W-OFF_W-1:0] alloc_line_i,
  input  logic [WAY_W-1:0]        alloc_way_i,
  input  logic                    inv_all_i,
  input  logic                    mem_req_ready_i,
  input  logic                    mem_resp_valid_i,
  output logic                    idle_o,
  output logic                    busy_o,
  output logic                    mem_req_valid_o,
  output logic [ADDR_W-1:0]       mem_req_addr_o,
  output logic                    beat_we_o,
  output logic [BEAT_W-1:0]       beat_idx_o,
  output logic                    fill_done_o,
  output logic                    fill_keep_o,
  output logic [ADDR_W-OFF_W-1:0] line_o,
  output logic [WAY_W-1:0]        way_o
);

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-OFF_W-1:0] line_q, line_d;
  logic [WAY_W-1:0]        way_q, way_d;
  logic                    drop_q, drop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      way_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      way_q   <= way_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    way_d       = way_q;
    drop_d      = drop_q;
    beat_we_o   = 1'b0;
    fill_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (alloc_i) begin
          state_d = REQ;
          line_d  = alloc_line_i;
          way_d   = alloc_way_i;
          drop_d  = 1'b0;
        end
      end
      REQ: begin
        if (inv_all_i) drop_d = 1'b1;
        if (mem_req_ready_i) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (inv_all_i) drop_d = 1'b1;
        if (mem_resp_valid_i) begin
          beat_we_o = 1'b1;
          cnt_d     = cnt_q + BEAT_W'(1);
          if (cnt_q == BEAT_W'(BEATS - 1)) begin
            fill_done_o = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle_o          = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign mem_req_valid_o = (state_q == REQ);
  assign mem_req_addr_o  = {line_q, {OFF_W{1'b0}}};
  assign beat_idx_o      = cnt_q;
  // A fence landing on the final beat has not reached drop_q yet.
  assign fill_keep_o     = ~(drop_q | inv_all_i);
  assign line_o          = line_q;
  assign way_o           = way_q;

endmodule

// File: rtl/l1_icache_np.sv
// N-port L1 instruction cache: tag/valid lookup with one-cycle response, miss
// merging into a single refill, per-set round-robin replacement and fence.i.
module l1_icache_np
  import icache_np_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned WAYS       = 8,
  parameter int unsigned SETS       = 128,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned ADDR_W     = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_PORTS-1:0]      req_valid_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
  output logic                      req_ready_o,
  output logic [NUM_PORTS-1:0]      resp_valid_o,
  output logic [NUM_PORTS-1:0]      resp_hit_o,
  output logic [NUM_PORTS*64-1:0]   resp_data_o,
  input  logic                      inv_all_i,
  output logic                      mem_req_valid_o,
  output logic [ADDR_W-1:0]         mem_req_addr_o,
  input  logic                      mem_req_ready_i,
  input  logic                      mem_resp_valid_i,
  input  logic [63:0]               mem_resp_data_i,
  output logic                      busy_o
);

  localparam int unsigned OFF_W  = bits_for(LINE_BYTES);
  localparam int unsigned IDX_W  = bits_for(SETS);
  localparam int unsigned TAG_W  = tag_bits(ADDR_W, LINE_BYTES, SETS);
  localparam int unsigned BEATS  = LINE_BYTES / 8;
  localparam int unsigned BEAT_W = bits_for(BEATS);
  localparam int unsigned WAY_W  = bits_for(WAYS);
  localparam int unsigned LINE_W = ADDR_W - OFF_W;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [63:0]      data_q  [SETS][WAYS][BEATS];

  logic [LINE_W-1:0] p_line [NUM_PORTS];
  logic [IDX_W-1:0]  p_idx  [NUM_PORTS];
  logic [TAG_W-1:0]  p_tag  [NUM_PORTS];
  logic [BEAT_W-1:0] p_word [NUM_PORTS];
  logic [NUM_PORTS*3-1:0] unused_addr_lo;

  logic              fsm_idle;
  logic [NUM_PORTS-1:0] accept;
  resp_t             resp_d [NUM_PORTS];
  resp_t             resp_q [NUM_PORTS];
  logic [LINE_W-1:0] rline_q [NUM_PORTS];

  logic [NUM_PORTS-1:0] miss_vec;
  logic              alloc;
  logic [LINE_W-1:0] alloc_line;
  logic [IDX_W-1:0]  alloc_set;
  logic [WAY_W-1:0]  victim;

  logic              beat_we, fill_done, fill_keep;
  logic [BEAT_W-1:0] beat_idx;
  logic [LINE_W-1:0] fill_line;
  logic [IDX_W-1:0]  fill_set;
  logic [TAG_W-1:0]  fill_tag;
  logic [WAY_W-1:0]  fill_way;

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    assign p_line[gp] = req_addr_i[gp*ADDR_W+OFF_W +: LINE_W];
    assign p_idx[gp]  = p_line[gp][IDX_W-1:0];
    assign p_tag[gp]  = p_line[gp][LINE_W-1:IDX_W];
    assign p_word[gp] = req_addr_i[gp*ADDR_W+3 +: BEAT_W];
    assign unused_addr_lo[gp*3 +: 3] = req_addr_i[gp*ADDR_W +: 3];

    assign resp_valid_o[gp]         = resp_q[gp].valid;
    assign resp_hit_o[gp]           = resp_q[gp].hit;
    assign resp_data_o[gp*64 +: 64] = resp_q[gp].data;
  end

  assign req_ready_o = fsm_idle & ~inv_all_i;
  assign accept      = req_valid_i & {NUM_PORTS{req_ready_o}};

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_d[p]       = '0;
      resp_d[p].valid = accept[p];
      for (int w = 0; w < WAYS; w++) begin
        if (accept[p] && valid_q[p_idx[p]][w] && (tag_q[p_idx[p]][w] == p_tag[p])) begin
          resp_d[p].hit  = 1'b1;
          resp_d[p].data = data_q[p_idx[p]][w][p_word[p]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        resp_q[p]  <= '0;
        rline_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        resp_q[p]  <= resp_d[p];
        rline_q[p] <= p_line[p];
      end
    end
  end

  // Lowest-index missing port owns the MSHR; same-line misses ride along for free.
  always_comb begin
    miss_vec   = '0;
    alloc_line = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      miss_vec[p] = resp_q[p].valid & ~resp_q[p].hit;
      if (miss_vec[p]) alloc_line = rline_q[p];
    end
  end

  assign alloc     = fsm_idle & (|miss_vec);
  assign alloc_set = alloc_line[IDX_W-1:0];

  always_comb begin
    victim = rr_q[alloc_set];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[alloc_set][w]) victim = WAY_W'(w);
    end
  end

  icache_refill_fsm #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W),
    .WAY_W  (WAY_W),
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W)
  ) u_refill (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_i          (alloc),
    .alloc_line_i     (alloc_line),
    .alloc_way_i      (victim),
    .inv_all_i        (inv_all_i),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_resp_valid_i (mem_resp_valid_i),
    .idle_o           (fsm_idle),
    .busy_o           (busy_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_addr_o   (mem_req_addr_o),
    .beat_we_o        (beat_we),
    .beat_idx_o       (beat_idx),
    .fill_done_o      (fill_done),
    .fill_keep_o      (fill_keep),
    .line_o           (fill_line),
    .way_o            (fill_way)
  );

  assign fill_set = fill_line[IDX_W-1:0];
  assign fill_tag = fill_line[LINE_W-1:IDX_W];

  // Victim is invalidated as the refill starts so it can never hit half-written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (inv_all_i) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else begin
        if (alloc) valid_q[alloc_set][victim] <= 1'b0;
        if (fill_done && fill_keep) valid_q[fill_set][fill_way] <= 1'b1;
      end
      if (fill_done) rr_q[fill_set] <= rr_q[fill_set] + WAY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (beat_we) data_q[fill_set][fill_way][beat_idx] <= mem_resp_data_i;
    if (fill_done) tag_q[fill_set][fill_way] <= fill_tag;
  end

endmodule
